// File: rtl/msx_slot_initiator_if.sv
`default_nettype none
// ============================================================================
// msx_slot_initiator_if : internal MSX-50BUS transaction signals
// Rev 1.0
// ============================================================================
interface msx_slot_initiator_if;
    logic [15:0] bus_address;
    logic        bus_memory;
    logic        bus_read;
    logic        bus_write;
    logic [7:0]  bus_write_data;
    logic        bus_read_ready;
    logic [7:0]  bus_read_data;

    modport master (
        output bus_address,
        output bus_memory,
        output bus_read,
        output bus_write,
        output bus_write_data,
        input  bus_read_ready,
        input  bus_read_data
    );

    modport slave (
        input  bus_address,
        input  bus_memory,
        input  bus_read,
        input  bus_write,
        input  bus_write_data,
        output bus_read_ready,
        output bus_read_data
    );
endinterface
`default_nettype wire

// File: rtl/msx_slot_initiator.sv
`default_nettype none
// ============================================================================
// msx_slot_initiator : turns MSX slot strobes into single internal bus cycles
// Rev 1.0
// ============================================================================
module msx_slot_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] slot_a,
    input  logic [7:0]  slot_d_in,
    output logic [7:0]  slot_d_out,
    output logic        slot_d_oe,
    input  logic        slot_n_sltsl,
    input  logic        slot_n_merq,
    input  logic        slot_n_iorq,
    input  logic        slot_n_rd,
    input  logic        slot_n_wr,
    msx_slot_initiator_if.master bus
);
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        READ_HOLD  = 2'd2,
        WRITE_HOLD = 2'd3
    } state_t;

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYCLES);

    logic [4:0]  r_sync_meta;
    logic [4:0]  r_sync;
    logic        w_sltsl_s, w_merq_s, w_iorq_s, w_rd_s, w_wr_s;
    logic        w_mem_sel, w_io_sel, w_sel;

    state_t      r_state, w_state_next;
    logic [7:0]  r_cnt, w_cnt_next, w_cnt_inc;
    logic [15:0] r_addr, w_addr_next;
    logic        r_mem, w_mem_next;
    logic [7:0]  r_wdata, w_wdata_next;
    logic [7:0]  r_dout, w_dout_next;
    logic        r_oe, w_oe_next;
    logic        r_read, w_read_next;
    logic        r_write, w_write_next;

    // Strobes are asynchronous to clk; address/data are only sampled once these settle.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sync_meta <= '1;
            r_sync      <= '1;
        end else begin
            r_sync_meta <= {slot_n_sltsl, slot_n_merq, slot_n_iorq, slot_n_rd, slot_n_wr};
            r_sync      <= r_sync_meta;
        end
    end

    assign {w_sltsl_s, w_merq_s, w_iorq_s, w_rd_s, w_wr_s} = r_sync;
    assign w_mem_sel = ~w_merq_s & ~w_sltsl_s;
    assign w_io_sel  = ~w_iorq_s;
    assign w_sel     = w_mem_sel | w_io_sel;
    assign w_cnt_inc = r_cnt + 8'd1;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_addr_next  = r_addr;
        w_mem_next   = r_mem;
        w_wdata_next = r_wdata;
        w_dout_next  = r_dout;
        w_oe_next    = r_oe;
        w_read_next  = 1'b0;
        w_write_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rd_s && w_sel) begin
                    w_addr_next  = slot_a;
                    w_mem_next   = w_mem_sel;
                    w_read_next  = 1'b1;
                    w_cnt_next   = 8'd0;
                    w_state_next = READ_WAIT;
                end else if (!w_wr_s && w_sel) begin
                    w_addr_next  = slot_a;
                    w_mem_next   = w_mem_sel;
                    w_wdata_next = slot_d_in;
                    w_write_next = 1'b1;
                    w_state_next = WRITE_HOLD;
                end
            end
            READ_WAIT: begin
                // A released strobe means the Z80 has already moved on; never drive late data.
                if (w_rd_s) begin
                    w_state_next = IDLE;
                end else if (bus.bus_read_ready) begin
                    w_dout_next  = bus.bus_read_data;
                    w_oe_next    = 1'b1;
                    w_state_next = READ_HOLD;
                end else begin
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc == c_TIMEOUT) begin
                        w_dout_next  = 8'hFF;
                        w_state_next = READ_HOLD;
                    end
                end
            end
            READ_HOLD: begin
                if (w_rd_s) begin
                    w_oe_next    = 1'b0;
                    w_state_next = IDLE;
                end
            end
            WRITE_HOLD: begin
                if (w_wr_s) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_addr  <= 16'h0000;
            r_mem   <= 1'b0;
            r_wdata <= 8'h00;
            r_dout  <= 8'hFF;
            r_oe    <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_addr  <= w_addr_next;
            r_mem   <= w_mem_next;
            r_wdata <= w_wdata_next;
            r_dout  <= w_dout_next;
            r_oe    <= w_oe_next;
            r_read  <= w_read_next;
            r_write <= w_write_next;
        end
    end

    assign slot_d_out         = r_dout;
    assign slot_d_oe          = r_oe;
    assign bus.bus_address    = r_addr;
    assign bus.bus_memory     = r_mem;
    assign bus.bus_read       = r_read;
    assign bus.bus_write      = r_write;
    assign bus.bus_write_data = r_wdata;
endmodule
`default_nettype wire

// File: tb/tb_msx_slot_initiator.sv
`default_nettype none
// ============================================================================
// tb_msx_slot_initiator : directed table, corner sequences and random cycles
// Rev 1.0
// ============================================================================
module tb_msx_slot_initiator;
    localparam int T = 15;

    typedef struct {
        bit          rd;
        bit          wr;
        bit          sltsl_n;
        bit          merq_n;
        bit          iorq_n;
        logic [15:0] a;
        logic [7:0]  din;
        int          len;
        int          dly;
        logic [7:0]  rdata;
    } stim_t;

    typedef struct {
        stim_t       s;
        int          n_rd;
        int          n_wr;
        logic [15:0] addr;
        bit          mem;
        logic [7:0]  wdata;
        bit          oe;
        logic [7:0]  dout;
    } vec_t;

    logic        clk = 1'b0;
    logic        n_reset = 1'b1;
    logic [15:0] slot_a = 16'h0000;
    logic [7:0]  slot_d_in = 8'h00;
    logic [7:0]  slot_d_out;
    logic        slot_d_oe;
    logic        slot_n_sltsl = 1'b1;
    logic        slot_n_merq = 1'b1;
    logic        slot_n_iorq = 1'b1;
    logic        slot_n_rd = 1'b1;
    logic        slot_n_wr = 1'b1;

    msx_slot_initiator_if bus();

    msx_slot_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .slot_a       (slot_a),
        .slot_d_in    (slot_d_in),
        .slot_d_out   (slot_d_out),
        .slot_d_oe    (slot_d_oe),
        .slot_n_sltsl (slot_n_sltsl),
        .slot_n_merq  (slot_n_merq),
        .slot_n_iorq  (slot_n_iorq),
        .slot_n_rd    (slot_n_rd),
        .slot_n_wr    (slot_n_wr),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int obs_nrd, obs_nwr, obs_pulse, obs_oe_first, obs_oe_last;
    bit obs_oe;
    logic [7:0] obs_oe_data;

    logic [15:0] m_addr;
    bit          m_mem;
    logic [7:0]  m_wdata;
    logic [7:0]  m_dout;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rd, bit wr, bit sl, bit mq, bit io, logic [15:0] a,
                                logic [7:0] din, int len, int dly, logic [7:0] rdata,
                                int nrd, int nwr, logic [15:0] addr, bit mem,
                                logic [7:0] wdata, bit oe, logic [7:0] dout);
        vec_t v;
        v.s.rd = rd; v.s.wr = wr; v.s.sltsl_n = sl; v.s.merq_n = mq; v.s.iorq_n = io;
        v.s.a = a; v.s.din = din; v.s.len = len; v.s.dly = dly; v.s.rdata = rdata;
        v.n_rd = nrd; v.n_wr = nwr; v.addr = addr; v.mem = mem; v.wdata = wdata;
        v.oe = oe; v.dout = dout;
        return v;
    endfunction

    function automatic void model_reset();
        m_addr = 16'h0000; m_mem = 1'b0; m_wdata = 8'h00; m_dout = 8'hFF;
    endfunction

    // Transaction-level expectation: pulse at edge 3, ready wins if it lands before the
    // strobe release is seen (edge len+3) and within T wait clocks; timeout otherwise.
    function automatic vec_t model(input stim_t s);
        vec_t r;
        bit mem_sel, sel;
        mem_sel = !s.sltsl_n && !s.merq_n;
        sel = mem_sel || !s.iorq_n;
        r.s = s; r.n_rd = 0; r.n_wr = 0; r.oe = 1'b0;
        if (s.rd && sel) begin
            r.n_rd = 1; m_addr = s.a; m_mem = mem_sel;
            if (s.dly >= 1 && s.dly <= T && s.dly + 1 <= s.len) begin
                r.oe = 1'b1; m_dout = s.rdata;
            end else if (T + 1 <= s.len) begin
                m_dout = 8'hFF;
            end
        end else if (s.wr && sel) begin
            r.n_wr = 1; m_addr = s.a; m_mem = mem_sel; m_wdata = s.din;
        end
        r.addr = m_addr; r.mem = m_mem; r.wdata = m_wdata; r.dout = m_dout;
        return r;
    endfunction

    task automatic run_cycle(input stim_t s);
        obs_nrd = 0; obs_nwr = 0; obs_pulse = -1; obs_oe = 1'b0;
        obs_oe_first = -1; obs_oe_last = -1; obs_oe_data = 8'h00;
        @(negedge clk);
        slot_a = s.a; slot_d_in = s.din;
        slot_n_sltsl = s.sltsl_n; slot_n_merq = s.merq_n; slot_n_iorq = s.iorq_n;
        slot_n_rd = !s.rd; slot_n_wr = !s.wr;
        for (int e = 1; e <= s.len + 4; e++) begin
            if (e == s.len + 1) begin
                slot_n_rd = 1'b1; slot_n_wr = 1'b1;
                slot_n_sltsl = 1'b1; slot_n_merq = 1'b1; slot_n_iorq = 1'b1;
            end
            if (obs_pulse > 0 && s.dly > 0 && e == obs_pulse + s.dly) begin
                bus.bus_read_ready = 1'b1; bus.bus_read_data = s.rdata;
            end else if (e <= 3) begin
                bus.bus_read_ready = 1'($urandom_range(0, 1)); bus.bus_read_data = 8'($urandom);
            end else begin
                bus.bus_read_ready = 1'b0; bus.bus_read_data = 8'($urandom);
            end
            @(posedge clk); #1;
            if (bus.bus_read) begin obs_nrd++; if (obs_pulse < 0) obs_pulse = e; end
            if (bus.bus_write) begin obs_nwr++; if (obs_pulse < 0) obs_pulse = e; end
            if (slot_d_oe) begin
                if (!obs_oe) obs_oe_first = e;
                obs_oe = 1'b1; obs_oe_last = e; obs_oe_data = slot_d_out;
            end
            @(negedge clk);
        end
        bus.bus_read_ready = 1'b0;
    endtask

    task automatic check_cycle(input string tag, input vec_t ex);
        chk({tag, ".n_read"}, obs_nrd, ex.n_rd);
        chk({tag, ".n_write"}, obs_nwr, ex.n_wr);
        if (ex.n_rd + ex.n_wr > 0) chk({tag, ".pulse_edge"}, obs_pulse, 3);
        chk({tag, ".address"}, bus.bus_address, ex.addr);
        chk({tag, ".memory"}, bus.bus_memory, ex.mem);
        chk({tag, ".wdata"}, bus.bus_write_data, ex.wdata);
        chk({tag, ".oe_seen"}, obs_oe, ex.oe);
        if (ex.oe) begin
            chk({tag, ".oe_first"}, obs_oe_first, 3 + ex.s.dly);
            chk({tag, ".oe_last"}, obs_oe_last, ex.s.len + 2);
            chk({tag, ".oe_data"}, obs_oe_data, ex.dout);
        end
        chk({tag, ".dout"}, slot_d_out, ex.dout);
        chk({tag, ".oe_end"}, slot_d_oe, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  ex;
        stim_t s;
        bit    got;

        bus.bus_read_ready = 1'b0;
        bus.bus_read_data  = 8'h00;
        tbl[0] = mk(0,1, 0,0,1, 16'h9800, 8'h5A, 10,  0, 8'h00, 0,1, 16'h9800, 1, 8'h5A, 0, 8'hFF);
        tbl[1] = mk(1,0, 0,0,1, 16'h9880, 8'h11, 22,  2, 8'h3C, 1,0, 16'h9880, 1, 8'h5A, 1, 8'h3C);
        tbl[2] = mk(1,0, 0,0,1, 16'h4000, 8'h22, 22,  0, 8'h00, 1,0, 16'h4000, 1, 8'h5A, 0, 8'hFF);
        tbl[3] = mk(0,1, 1,1,0, 16'h00A0, 8'h07, 10,  0, 8'h00, 0,1, 16'h00A0, 0, 8'h07, 0, 8'hFF);
        tbl[4] = mk(1,0, 1,0,1, 16'h1234, 8'h33, 10,  2, 8'h44, 0,0, 16'h00A0, 0, 8'h07, 0, 8'hFF);
        tbl[5] = mk(1,1, 0,0,1, 16'h8000, 8'h99, 22,  1, 8'hC3, 1,0, 16'h8000, 1, 8'h07, 1, 8'hC3);
        tbl[6] = mk(1,0, 0,0,0, 16'h7FFF, 8'h44, 22, 15, 8'h81, 1,0, 16'h7FFF, 1, 8'h07, 1, 8'h81);
        tbl[7] = mk(1,0, 1,1,0, 16'h0055, 8'h55, 22, 16, 8'h18, 1,0, 16'h0055, 0, 8'h07, 0, 8'hFF);

        #2 n_reset = 1'b0;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        model_reset();
        @(negedge clk);
        chk("reset.dout", slot_d_out, 8'hFF);
        chk("reset.oe", slot_d_oe, 1'b0);
        chk("reset.read", bus.bus_read, 1'b0);
        chk("reset.write", bus.bus_write, 1'b0);
        chk("reset.memory", bus.bus_memory, 1'b0);
        chk("reset.address", bus.bus_address, 16'h0000);
        chk("reset.wdata", bus.bus_write_data, 8'h00);

        // Ready while idle must not reach the slot pins.
        bus.bus_read_ready = 1'b1; bus.bus_read_data = 8'hAA;
        repeat (2) @(negedge clk);
        bus.bus_read_ready = 1'b0;
        chk("idle_ready.oe", slot_d_oe, 1'b0);
        chk("idle_ready.dout", slot_d_out, 8'hFF);

        for (int i = 0; i < 8; i++) begin
            ex = model(tbl[i].s);
            run_cycle(tbl[i].s);
            check_cycle($sformatf("tbl%0d", i), tbl[i]);
        end

        // Abort: rd released while waiting; late ready lands in IDLE.
        s = tbl[1].s; s.a = 16'h2222; s.len = 5; s.dly = 6; s.rdata = 8'h66;
        ex = model(s);
        run_cycle(s);
        check_cycle("abort", ex);
        chk("abort.dout_kept", slot_d_out, 8'hFF);

        // Asynchronous reset while driving read data.
        @(negedge clk);
        slot_n_sltsl = 1'b0; slot_n_merq = 1'b0; slot_a = 16'h3333; slot_n_rd = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.bus_read) got = 1'b1;
        end
        chk("rst_hold.read_pulse", got, 1'b1);
        @(negedge clk);
        bus.bus_read_ready = 1'b1; bus.bus_read_data = 8'h5E;
        @(posedge clk); #1;
        bus.bus_read_ready = 1'b0;
        chk("rst_hold.oe_before", slot_d_oe, 1'b1);
        chk("rst_hold.dout_before", slot_d_out, 8'h5E);
        #2 n_reset = 1'b0;
        #1;
        chk("rst_hold.oe", slot_d_oe, 1'b0);
        chk("rst_hold.dout", slot_d_out, 8'hFF);
        chk("rst_hold.address", bus.bus_address, 16'h0000);
        chk("rst_hold.memory", bus.bus_memory, 1'b0);
        chk("rst_hold.wdata", bus.bus_write_data, 8'h00);
        chk("rst_hold.read", bus.bus_read, 1'b0);
        chk("rst_hold.write", bus.bus_write, 1'b0);
        @(negedge clk);
        slot_n_rd = 1'b1; slot_n_sltsl = 1'b1; slot_n_merq = 1'b1;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);

        for (int i = 0; i < 50; i++) begin
            s.rd = 1'($urandom_range(0, 1));
            s.wr = 1'($urandom_range(0, 1));
            s.sltsl_n = 1'($urandom_range(0, 1));
            s.merq_n = 1'($urandom_range(0, 1));
            s.iorq_n = 1'($urandom_range(0, 1));
            s.a = 16'($urandom);
            s.din = 8'($urandom);
            s.len = int'($urandom_range(1, 28));
            s.dly = int'($urandom_range(0, 20));
            s.rdata = 8'($urandom);
            ex = model(s);
            run_cycle(s);
            check_cycle($sformatf("rnd%0d", i), ex);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/msx_slot_initiator.md
# msx_slot_initiator

Cartridge-edge bus initiator: samples the raw MSX slot strobes and turns each slot memory or I/O cycle into one internal MSX-50BUS transaction. It emits single-clock `bus_read`/`bus_write` pulses to internal responders such as the SCC core. It waits for `bus_read_ready` and returns the read data to the slot pins, with direction control. It sits between the slot pin buffers and every internal bus responder.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 15: clocks to wait for `bus_read_ready` before abandoning a read. Range 1..255.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `n_reset` in 1: asynchronous, active-low reset.
- `slot_a` in 16: slot address pins.
- `slot_d_in` in 8: slot data pins, input side.
- `slot_d_out` out 8: data driven to the slot during reads.
- `slot_d_oe` out 1: 1 = drive `slot_d_out` onto the slot data pins.
- `slot_n_sltsl` in 1: slot select, active-low.
- `slot_n_merq` in 1: memory request, active-low.
- `slot_n_iorq` in 1: I/O request, active-low.
- `slot_n_rd` in 1: read strobe, active-low.
- `slot_n_wr` in 1: write strobe, active-low.
- `bus_address` out 16: latched transaction address.
- `bus_memory` out 1: 1 = memory cycle, 0 = I/O cycle.
- `bus_read` out 1: one-clock read request pulse.
- `bus_write` out 1: one-clock write request pulse.
- `bus_write_data` out 8: latched write data.
- `bus_read_ready` in 1: responder's read-data-valid strobe.
- `bus_read_data` in 8: responder read data; valid while `bus_read_ready`=1.

## Operation
- Synchronisers:
  - `slot_n_sltsl`, `slot_n_merq`, `slot_n_iorq`, `slot_n_rd` and `slot_n_wr` each pass through a 2-flop synchroniser.
  - `slot_a` and `slot_d_in` are not synchronised. They are captured only when the FSM accepts a cycle, by which time they are stable.
- Selection:
  - `mem_sel` = synced merq=0 AND synced sltsl=0.
  - `io_sel` = synced iorq=0. Sltsl is ignored for I/O.
  - `mem_sel` has priority if both are true.
- FSM states: IDLE, READ_WAIT, READ_HOLD, WRITE_HOLD.
- IDLE:
  - Read start: synced rd=0 and (`mem_sel` or `io_sel`). Latch `bus_address`←`slot_a` and `bus_memory`←`mem_sel`. Pulse `bus_read`. Clear the timeout counter. Go to READ_WAIT.
  - Write start: synced wr=0 and a select is true. Latch the address, `bus_memory` and `bus_write_data`←`slot_d_in`. Pulse `bus_write`. Go to WRITE_HOLD.
  - If rd and wr are both low, the read wins.
- READ_WAIT (`bus_read_ready` is evaluated only in this state, from the cycle after the `bus_read` pulse):
  - Ready=1: `slot_d_out`←`bus_read_data`, `slot_d_oe`←1, go to READ_HOLD.
  - Otherwise the counter increments. When it reaches `TIMEOUT_CYCLES`: `slot_d_out`←FFh, `slot_d_oe` stays 0 (pull-ups supply FFh), go to READ_HOLD.
  - Synced rd returns high first: go to IDLE, `slot_d_oe` stays 0.
- READ_HOLD: when synced rd=1, `slot_d_oe`←0 and go to IDLE.
- WRITE_HOLD: when synced wr=1, go to IDLE. Exactly one `bus_write` is issued per slot strobe.
- `bus_read_ready` is ignored in every state other than READ_WAIT.
- `bus_address`, `bus_memory` and `bus_write_data` hold their values until the next accepted cycle.

## Timing
- Reset values:
  - `slot_d_out`=FFh.
  - `slot_d_oe`=0, `bus_read`=0, `bus_write`=0, `bus_memory`=0.
  - `bus_address`=0000h, `bus_write_data`=00h.
  - State IDLE, synchroniser flops all 1.
- Reset asserted mid-cycle drops `slot_d_oe` immediately (asynchronous).
- Strobe latency: a strobe low sampled at edge k reaches the FSM at k+1. The `bus_read`/`bus_write` pulse is registered at edge k+2 and is high for exactly one clock.
- Ready sampled high at edge r: `slot_d_oe`=1 and `slot_d_out` are valid after edge r. Minimum is pulse edge + 1.
- `slot_d_oe` falls on the edge that registers the state change after synced rd=1, i.e. 2 edges after the pin rises.
- Timeout: no ready in `TIMEOUT_CYCLES` consecutive READ_WAIT clocks leads to READ_HOLD on the next edge.
- Back-to-back cycles need a synced strobe high for at least 1 clock between them. No new cycle is accepted while in a HOLD state.

## Test plan
- Memory write:
  - Stimulus: sltsl=0, merq=0, `slot_a`=9800h, `slot_d_in`=5Ah, wr low for 10 clocks.
  - Response: one `bus_write` pulse at the 3rd edge, `bus_address`=9800h, `bus_memory`=1, `bus_write_data`=5Ah. No second pulse.
- Memory read with ready:
  - Stimulus: `slot_a`=9880h, responder raises ready 2 clocks after `bus_read` with data 3Ch.
  - Response: `slot_d_oe`=1, `slot_d_out`=3Ch until rd high. `slot_d_oe`=0 two edges after rd rises.
- Read timeout:
  - Stimulus: no ready, `TIMEOUT_CYCLES`=15.
  - Response: `slot_d_oe` stays 0, `slot_d_out`=FFh after 15 wait clocks, FSM in READ_HOLD, returns to IDLE on rd high.
- I/O write:
  - Stimulus: iorq=0, sltsl=1, `slot_a`=00A0h, data 07h.
  - Response: `bus_memory`=0, `bus_write` pulsed once.
- Abort and reset:
  - Abort stimulus: rd released during READ_WAIT. Response: no `slot_d_oe`, IDLE.
  - Reset stimulus: `n_reset` low during READ_HOLD. Response: `slot_d_oe`=0 immediately, all outputs at reset values.
- Unselected and simultaneous strobes:
  - Stimulus: sltsl=1 with merq=0 and rd low. Response: no `bus_read`.
  - Stimulus: rd and wr low together. Response: only `bus_read` is pulsed.
